// File: rtl/fifo_burst_drain.sv
// Read-side master for a 16x8 fifo: pops stored bytes in fixed-length bursts
// onto a valid/ready stream through a 2-entry skid buffer, framing with m_last.
//
// state   | meaning
// S_IDLE  | waiting for a full burst, flush, or idle timeout with data stored
// S_BURST | popping r_beats more bytes from the fifo into the skid buffer
module fifo_burst_drain #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 5,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              f_ren,
  input  logic [DATA_W-1:0] f_rdata,
  input  logic              f_empty,
  input  logic [CNT_W-1:0]  f_count,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              err
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LP_BURST = CNT_W'(BURST_LEN);
  localparam logic [TMO_W-1:0] LP_TMO   = TMO_W'(TIMEOUT);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_beats;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_err;
  logic [DATA_W-1:0] r_data0, r_data1;
  logic              r_last0, r_last1;
  logic [1:0]        r_occ;

  logic              w_valid, w_pop, w_space, w_ren, w_tag_last;
  logic              w_nonzero, w_start;
  logic [CNT_W-1:0]  w_first_beats;

  assign w_valid       = (r_occ != 2'd0);
  assign w_pop         = w_valid && m_ready;
  // a full skid buffer can still accept a read in the cycle it hands a beat out
  assign w_space       = (r_occ < 2'd2) || w_pop;
  assign w_ren         = (r_state == S_BURST) && (r_beats != '0) && !f_empty && w_space;
  assign w_tag_last    = (r_beats == CNT_W'(1));
  assign w_nonzero     = (f_count != '0);
  assign w_start       = (f_count >= LP_BURST) || (flush && w_nonzero) ||
                         ((r_tmo == LP_TMO) && w_nonzero);
  assign w_first_beats = (f_count < LP_BURST) ? f_count : LP_BURST;

  assign f_ren   = w_ren;
  assign m_valid = w_valid;
  assign m_data  = r_data0;
  assign m_last  = r_last0 && w_valid;
  assign busy    = (r_state != S_IDLE) || w_valid;
  assign err     = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beats <= '0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_BURST;
            r_beats <= w_first_beats;
            r_tmo   <= '0;
          end else if (!w_nonzero) begin
            r_tmo <= '0;
          end else if (r_tmo != LP_TMO) begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_BURST: begin
          r_tmo <= '0;
          // fifo ran dry mid-burst: hold here until data shows up again
          if (f_empty && (r_beats != '0)) r_err <= 1'b1;
          if (w_ren) begin
            r_beats <= r_beats - CNT_W'(1);
            if (w_tag_last) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data0 <= '0;
      r_data1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_occ   <= 2'd0;
    end else begin
      case ({w_ren, w_pop})
        2'b10: begin
          if (r_occ == 2'd0) begin
            r_data0 <= f_rdata;
            r_last0 <= w_tag_last;
          end else begin
            r_data1 <= f_rdata;
            r_last1 <= w_tag_last;
          end
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_data0 <= r_data1;
          r_last0 <= r_last1;
          r_occ   <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_data0 <= f_rdata;
            r_last0 <= w_tag_last;
          end else begin
            r_data0 <= r_data1;
            r_last0 <= r_last1;
            r_data1 <= f_rdata;
            r_last1 <= w_tag_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
